ghr_spec: RTL and testbench

//  Parametrised global history register with speculative update and recovery.
//  - Fetch shifts each predicted conditional-branch direction into a speculative history.
//  - Execute resolves branches in order and shifts the actual outcome into an

---
 rtl/ghr_pkg.sv | 18 +
 rtl/ghr_spec_if.sv | 36 +++
 rtl/ghr_ckpt_fifo.sv | 57 +++++
 rtl/ghr_spec.sv | 106 ++++++++++
 tb/tb_ghr_spec.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ghr_pkg.sv
// Shared constants and the history shift helper for the global history register.
package ghr_pkg;

    localparam int GHR_HIST_W_DEF     = 8;
    localparam int GHR_CKPT_DEPTH_DEF = 4;
    localparam int BR_OP_COND_BIT     = 0;
    localparam int PERF_CNT_W         = 32;
    localparam int GHR_HIST_MAX_W     = 64;

    // Callers zero-extend into the wide form and cast the result back to their width.
    function automatic logic [GHR_HIST_MAX_W-1:0] hist_shift(
        input logic [GHR_HIST_MAX_W-1:0] h,
        input logic                      b
    );
        return {h[GHR_HIST_MAX_W-2:0], b};
    endfunction

endpackage

// File: rtl/ghr_spec_if.sv
// Fetch/execute-facing signal bundle of the global history register.
interface ghr_spec_if
    import ghr_pkg::*;
#(
    parameter int HIST_W = GHR_HIST_W_DEF
);
    logic                  stall_f_i;
    logic                  branch_f_i;
    logic                  pred_taken_f_i;
    logic                  stall_e_i;
    logic [1:0]            branch_op_e_i;
    logic                  pc_src_res_e_i;
    logic [HIST_W-1:0]     spec_hist_o;
    logic [HIST_W-1:0]     arch_hist_o;
    logic                  mispredict_e_o;
    logic                  ckpt_full_o;
    logic                  ckpt_empty_o;
    logic                  overflow_o;
    logic [PERF_CNT_W-1:0] br_cnt_o;
    logic [PERF_CNT_W-1:0] mp_cnt_o;

    modport master (
        output stall_f_i, branch_f_i, pred_taken_f_i,
        output stall_e_i, branch_op_e_i, pc_src_res_e_i,
        input  spec_hist_o, arch_hist_o, mispredict_e_o,
        input  ckpt_full_o, ckpt_empty_o, overflow_o, br_cnt_o, mp_cnt_o
    );

    modport slave (
        input  stall_f_i, branch_f_i, pred_taken_f_i,
        input  stall_e_i, branch_op_e_i, pc_src_res_e_i,
        output spec_hist_o, arch_hist_o, mispredict_e_o,
        output ckpt_full_o, ckpt_empty_o, overflow_o, br_cnt_o, mp_cnt_o
    );

endinterface

// File: rtl/ghr_ckpt_fifo.sv
// 1-bit checkpoint FIFO of predicted directions; flush dominates push and pop.
module ghr_ckpt_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic push_i,
    input  logic pop_i,
    input  logic flush_i,
    input  logic din_i,
    output logic dout_o,
    output logic full_o,
    output logic empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_INC = (PTR_W + 1)'(1);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] mem_q;
    logic             wr_en_w, rd_en_w;

    // The extra pointer MSB distinguishes a full ring from an empty one.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rd_en_w = pop_i & ~empty_o;
    assign wr_en_w = push_i & (~full_o | rd_en_w);
    assign dout_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en_w) wr_ptr_d = wr_ptr_q + PTR_INC;
            if (rd_en_w) rd_ptr_d = rd_ptr_q + PTR_INC;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_w && !flush_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
    end

endmodule

// File: rtl/ghr_spec.sv
// Speculative/architectural global history register with checkpoint-based repair.
// Optional resolve/mispredict counters are built when GHR_PERF_EN is defined.
module ghr_spec
    import ghr_pkg::*;
#(
    parameter int                HIST_W     = GHR_HIST_W_DEF,
    parameter int                CKPT_DEPTH = GHR_CKPT_DEPTH_DEF,
    parameter logic [HIST_W-1:0] RESET_HIST = HIST_W'(1)
) (
    input  logic     clk_i,
    input  logic     reset_n_i,
    ghr_spec_if.slave bus
);
    logic              push_w, resolve_w, mispredict_w, res_empty_w;
    logic              recover_w, pop_w, fifo_push_w, push_ok_w;
    logic              head_w, full_w, empty_w;
    logic [HIST_W-1:0] spec_q, spec_d, arch_q, arch_d;
    logic [HIST_W-1:0] arch_new_w, spec_new_w;
    logic              ovf_q, ovf_d;
    logic [1:0]        unused_op_w;

    assign unused_op_w = bus.branch_op_e_i;

    assign push_w       = bus.branch_f_i & ~bus.stall_f_i;
    assign resolve_w    = bus.branch_op_e_i[BR_OP_COND_BIT] & ~bus.stall_e_i;
    assign mispredict_w = resolve_w & ~empty_w & (bus.pc_src_res_e_i ^ head_w);
    assign res_empty_w  = resolve_w & empty_w;
    // Either case rebuilds the speculative history from the new architectural one.
    assign recover_w    = mispredict_w | res_empty_w;
    assign pop_w        = resolve_w & ~recover_w;
    assign fifo_push_w  = push_w & ~recover_w;
    assign push_ok_w    = fifo_push_w & (~full_w | pop_w);

    assign arch_new_w = HIST_W'(hist_shift(GHR_HIST_MAX_W'(arch_q), bus.pc_src_res_e_i));
    assign spec_new_w = HIST_W'(hist_shift(GHR_HIST_MAX_W'(spec_q), bus.pred_taken_f_i));

    ghr_ckpt_fifo #(
        .DEPTH (CKPT_DEPTH)
    ) u_ckpt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (fifo_push_w),
        .pop_i     (pop_w),
        .flush_i   (recover_w),
        .din_i     (bus.pred_taken_f_i),
        .dout_o    (head_w),
        .full_o    (full_w),
        .empty_o   (empty_w)
    );

    always_comb begin
        spec_d = spec_q;
        arch_d = arch_q;
        ovf_d  = ovf_q;
        if (resolve_w) arch_d = arch_new_w;
        if (recover_w) begin
            spec_d = arch_new_w;
        end else if (push_ok_w) begin
            spec_d = spec_new_w;
        end
        if (res_empty_w || (fifo_push_w && !push_ok_w)) ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            spec_q <= RESET_HIST;
            arch_q <= RESET_HIST;
            ovf_q  <= 1'b0;
        end else begin
            spec_q <= spec_d;
            arch_q <= arch_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.spec_hist_o    = spec_q;
    assign bus.arch_hist_o    = arch_q;
    assign bus.mispredict_e_o = mispredict_w;
    assign bus.ckpt_full_o    = full_w;
    assign bus.ckpt_empty_o   = empty_w;
    assign bus.overflow_o     = ovf_q;

`ifdef GHR_PERF_EN
    localparam logic [PERF_CNT_W-1:0] CNT_INC = PERF_CNT_W'(1);

    logic [PERF_CNT_W-1:0] br_cnt_q, mp_cnt_q;

    // Resolve-while-empty counts as a resolve but never as a mispredict.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (resolve_w)    br_cnt_q <= br_cnt_q + CNT_INC;
            if (mispredict_w) mp_cnt_q <= mp_cnt_q + CNT_INC;
        end
    end

    assign bus.br_cnt_o = br_cnt_q;
    assign bus.mp_cnt_o = mp_cnt_q;
`else
    assign bus.br_cnt_o = '0;
    assign bus.mp_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ghr_spec.sv
// Scoreboard bench for ghr_spec: a queue-based reference model predicts each cycle's outcome.
module tb_ghr_spec;

    localparam int HW    = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [HW-1:0] spec;
        logic [HW-1:0] arch;
        logic          full;
        logic          empty;
        logic          ovf;
        logic          mp;
        logic [31:0]   br_cnt;
        logic [31:0]   mp_cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    exp_t          sb[$];
    bit            mq[$];
    logic [HW-1:0] m_spec, m_arch;
    logic          m_ovf;
    logic [31:0]   m_br, m_mp;

    ghr_spec_if #(.HIST_W(HW)) bus ();

    ghr_spec #(
        .HIST_W     (HW),
        .CKPT_DEPTH (DEPTH),
        .RESET_HIST (8'h01)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_spec = 8'h01;
        m_arch = 8'h01;
        m_ovf  = 1'b0;
        m_br   = '0;
        m_mp   = '0;
        mq.delete();
    endtask

    function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef GHR_PERF_EN
        return v;
`else
        return 32'(v & 32'h0);
`endif
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic bf, input logic pf, input logic sf,
                        input logic [1:0] op, input logic act, input logic se);
        exp_t e;
        logic push, res, mpx, re;
        int   n;
        push = bf & ~sf;
        res  = op[0] & ~se;
        n    = mq.size();
        mpx  = res && (n != 0) && (act != mq[0]);
        re   = res && (n == 0);
        if (res) begin
            m_br   = m_br + 1;
            m_arch = {m_arch[HW-2:0], act};
        end
        if (mpx) m_mp = m_mp + 1;
        if (mpx || re) begin
            m_spec = m_arch;
            mq.delete();
            if (re) m_ovf = 1'b1;
        end else begin
            if (res) void'(mq.pop_front());
            if (push) begin
                if (n < DEPTH || res) begin
                    m_spec = {m_spec[HW-2:0], pf};
                    mq.push_back(pf);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        e.spec   = m_spec;
        e.arch   = m_arch;
        e.full   = (mq.size() == DEPTH);
        e.empty  = (mq.size() == 0);
        e.ovf    = m_ovf;
        e.mp     = mpx;
        e.br_cnt = cnt_exp(m_br);
        e.mp_cnt = cnt_exp(m_mp);
        sb.push_back(e);

        bus.branch_f_i     = bf;
        bus.pred_taken_f_i = pf;
        bus.stall_f_i      = sf;
        bus.branch_op_e_i  = op;
        bus.pc_src_res_e_i = act;
        bus.stall_e_i      = se;
        #1;
        check_eq("mispredict", 32'(bus.mispredict_e_o), 32'(sb[0].mp));
        @(posedge clk);
        #1;
        bus.branch_f_i    = 1'b0;
        bus.branch_op_e_i = 2'b00;
        e = sb.pop_front();
        check_eq("spec_hist", 32'(bus.spec_hist_o), 32'(e.spec));
        check_eq("arch_hist", 32'(bus.arch_hist_o), 32'(e.arch));
        check_eq("ckpt_full", 32'(bus.ckpt_full_o), 32'(e.full));
        check_eq("ckpt_empty", 32'(bus.ckpt_empty_o), 32'(e.empty));
        check_eq("overflow", 32'(bus.overflow_o), 32'(e.ovf));
        check_eq("br_cnt", bus.br_cnt_o, e.br_cnt);
        check_eq("mp_cnt", bus.mp_cnt_o, e.mp_cnt);
        @(negedge clk);
    endtask

    task automatic push_only(input logic pf);
        step(1'b1, pf, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic resolve_only(input logic act);
        step(1'b0, 1'b0, 1'b0, 2'b11, act, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.branch_f_i     = 1'b0;
        bus.pred_taken_f_i = 1'b0;
        bus.stall_f_i      = 1'b0;
        bus.branch_op_e_i  = 2'b00;
        bus.pc_src_res_e_i = 1'b0;
        bus.stall_e_i      = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_spec", 32'(bus.spec_hist_o), 32'h01);
        check_eq("rst_arch", 32'(bus.arch_hist_o), 32'h01);
        check_eq("rst_empty", 32'(bus.ckpt_empty_o), 32'h1);
        check_eq("rst_full", 32'(bus.ckpt_full_o), 32'h0);
        check_eq("rst_ovf", 32'(bus.overflow_o), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Speculative pushes T,T,N from 8'h01
        push_only(1'b1); check_eq("s2_spec0", 32'(bus.spec_hist_o), 32'h03);
        push_only(1'b1); check_eq("s2_spec1", 32'(bus.spec_hist_o), 32'h07);
        push_only(1'b0); check_eq("s2_spec2", 32'(bus.spec_hist_o), 32'h0E);
        check_eq("s2_arch", 32'(bus.arch_hist_o), 32'h01);

        // In-order correct resolves
        resolve_only(1'b1);
        resolve_only(1'b1);
        resolve_only(1'b0);
        check_eq("s3_arch", 32'(bus.arch_hist_o), 32'h0E);
        check_eq("s3_empty", 32'(bus.ckpt_empty_o), 32'h1);

        // Mispredict with a same-cycle push: 8'h0E shifted with 0 gives 8'h1C on both
        push_only(1'b1);
        push_only(1'b1);
        push_only(1'b1);
        check_eq("s4_spec_pre", 32'(bus.spec_hist_o), 32'h77);
        step(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
        check_eq("s4_arch", 32'(bus.arch_hist_o), 32'h1C);
        check_eq("s4_spec", 32'(bus.spec_hist_o), 32'h1C);
        check_eq("s4_empty", 32'(bus.ckpt_empty_o), 32'h1);
`ifdef GHR_PERF_EN
        check_eq("s4_br_cnt", bus.br_cnt_o, 32'd4);
        check_eq("s4_mp_cnt", bus.mp_cnt_o, 32'd1);
`else
        check_eq("s4_br_cnt", bus.br_cnt_o, 32'd0);
        check_eq("s4_mp_cnt", bus.mp_cnt_o, 32'd0);
`endif

        // Fill, overflow drop, then push plus correct resolve while full
        push_only(1'b1);
        push_only(1'b0);
        push_only(1'b1);
        push_only(1'b0);
        check_eq("s5_full", 32'(bus.ckpt_full_o), 32'h1);
        check_eq("s5_spec_full", 32'(bus.spec_hist_o), 32'hCA);
        push_only(1'b1);
        check_eq("s5_drop_spec", 32'(bus.spec_hist_o), 32'hCA);
        check_eq("s5_ovf", 32'(bus.overflow_o), 32'h1);
        step(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        check_eq("s5_pp_spec", 32'(bus.spec_hist_o), 32'h95);
        check_eq("s5_pp_arch", 32'(bus.arch_hist_o), 32'h39);
        check_eq("s5_pp_full", 32'(bus.ckpt_full_o), 32'h1);

        // Both stalls held with branch inputs asserted
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
        check_eq("s6_spec", 32'(bus.spec_hist_o), 32'h95);
        check_eq("s6_arch", 32'(bus.arch_hist_o), 32'h39);

        // Leave three entries queued, then reset asynchronously mid-cycle
        resolve_only(1'b0);
        check_eq("s1_arch_pre", 32'(bus.arch_hist_o), 32'h72);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("s1_spec", 32'(bus.spec_hist_o), 32'h01);
        check_eq("s1_arch", 32'(bus.arch_hist_o), 32'h01);
        check_eq("s1_empty", 32'(bus.ckpt_empty_o), 32'h1);
        check_eq("s1_ovf", 32'(bus.overflow_o), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Resolve on an empty checkpoint FIFO
        resolve_only(1'b1);
        check_eq("re_arch", 32'(bus.arch_hist_o), 32'h03);
        check_eq("re_spec", 32'(bus.spec_hist_o), 32'h03);
        check_eq("re_ovf", 32'(bus.overflow_o), 32'h1);

        // Mixed traffic against the model
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
